// File: rtl/b_resp_fifo_if.sv
// ---------------------------------------------------------------------------
// b_resp_fifo_if
// Write-response (B channel) handshake bundle for the crossbar B buffer.
//   in_BID/in_BRESP/in_valid  : producer -> FIFO enqueue side
//   in_ready                  : FIFO -> producer, space available
//   out_BID/out_BRESP/out_valid : FIFO -> consumer, head entry
//   out_ready                 : consumer -> FIFO, head accepted
// Modports: slave = the FIFO itself, master = the surrounding logic that
// drives enqueue and consumes the head.
// ---------------------------------------------------------------------------
interface b_resp_fifo_if #(
    parameter int ID_WIDTH = 4
);
    logic [ID_WIDTH-1:0] in_BID;
    logic [1:0]          in_BRESP;
    logic                in_valid;
    logic                in_ready;
    logic [ID_WIDTH-1:0] out_BID;
    logic [1:0]          out_BRESP;
    logic                out_valid;
    logic                out_ready;

    modport slave (
        input  in_BID, in_BRESP, in_valid, out_ready,
        output in_ready, out_BID, out_BRESP, out_valid
    );

    modport master (
        output in_BID, in_BRESP, in_valid, out_ready,
        input  in_ready, out_BID, out_BRESP, out_valid
    );
endinterface

// File: rtl/b_resp_fifo.sv
// ---------------------------------------------------------------------------
// b_resp_fifo
// Single-clock AXI B-channel buffer: circular buffer of DEPTH entries (any
// DEPTH >= 2), first-word-fall-through head, occupancy count, almost-full
// flag, synchronous flush and a saturating count of error responses.
// Ports:
//   clk, nrst     : clock, asynchronous active-low reset
//   flush         : synchronous clear of all entries (err_count kept)
//   err_clr       : synchronous clear of err_count
//   bus (slave)   : enqueue / dequeue handshakes (see b_resp_fifo_if)
//   count         : current occupancy
//   almost_full   : count >= AF_THRESH
//   err_count     : accepted entries with BRESP[1]=1, saturating
// ---------------------------------------------------------------------------
module b_resp_fifo #(
    parameter int ID_WIDTH      = 4,
    parameter int DEPTH         = 8,
    parameter int AF_THRESH     = DEPTH - 2,
    parameter int ERR_CNT_WIDTH = 8,
    localparam int CW           = $clog2(DEPTH + 1),
    localparam int PW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     flush,
    input  logic                     err_clr,
    b_resp_fifo_if.slave             bus,
    output logic [CW-1:0]            count,
    output logic                     almost_full,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    logic [ID_WIDTH-1:0]      mem_id_q   [DEPTH];
    logic [1:0]               mem_resp_q [DEPTH];
    logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]            count_q, count_d;
    logic [ERR_CNT_WIDTH-1:0] err_q;
    logic                     push, pop;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshake flags come only from registered state, so in_ready has no
    // path from out_ready: a full FIFO refuses a push even during a pop.
    assign bus.in_ready  = (count_q != CW'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    assign bus.out_BID   = mem_id_q[rd_ptr_q];
    assign bus.out_BRESP = mem_resp_q[rd_ptr_q];
    assign count         = count_q;
    assign almost_full   = (count_q >= CW'(AF_THRESH));
    assign err_count     = err_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // Storage is cleared so the head drives zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_id_q[i]   <= '0;
                mem_resp_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Only the slot at wr_ptr is written; with count < DEPTH it is
            // never the head, so the head stays stable under pushes.
            if (push) begin
                mem_id_q[wr_ptr_q]   <= bus.in_BID;
                mem_resp_q[wr_ptr_q] <= bus.in_BRESP;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

    // A push discarded by flush is not an accepted entry, so it is not
    // counted; flush itself leaves the counter alone.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err_q <= '0;
        end else if (err_clr) begin
            err_q <= '0;
        end else if (push && !flush && bus.in_BRESP[1] && (err_q != '1)) begin
            err_q <= err_q + ERR_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_b_resp_fifo.sv
// ---------------------------------------------------------------------------
// tb_b_resp_fifo
// Directed bench for b_resp_fifo with DEPTH=6, AF_THRESH=4, ERR_CNT_WIDTH=2.
// Inputs change 1ns after each rising edge; outputs are sampled at the same
// point, before the next edge.
// ---------------------------------------------------------------------------
module tb_b_resp_fifo;

    localparam int IDW = 4;
    localparam int DEP = 6;
    localparam int ECW = 2;
    localparam int CW  = $clog2(DEP + 1);

    logic           clk = 1'b0;
    logic           nrst;
    logic           flush;
    logic           err_clr;
    logic [CW-1:0]  count;
    logic           almost_full;
    logic [ECW-1:0] err_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [IDW-1:0] exp_q[$];
    logic [1:0]     resp_v [5];
    logic [ECW-1:0] err_v  [5];

    b_resp_fifo_if #(.ID_WIDTH(IDW)) bif ();

    b_resp_fifo #(
        .ID_WIDTH      (IDW),
        .DEPTH         (DEP),
        .AF_THRESH     (4),
        .ERR_CNT_WIDTH (ECW)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .flush       (flush),
        .err_clr     (err_clr),
        .bus         (bif.slave),
        .count       (count),
        .almost_full (almost_full),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [IDW-1:0] id, input logic [1:0] r,
                       input logic rdy);
        bif.in_valid  = v;
        bif.in_BID    = id;
        bif.in_BRESP  = r;
        bif.out_ready = rdy;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b0; flush = 1'b0; err_clr = 1'b0;
        drv(1'b0, '0, 2'b00, 1'b0);
        #3;
        // Reset state
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(bif.out_valid), 0);
        chk("rst_in_ready", 32'(bif.in_ready), 1);
        chk("rst_almost_full", 32'(almost_full), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_out_BID", 32'(bif.out_BID), 0);
        chk("rst_out_BRESP", 32'(bif.out_BRESP), 0);
        #4 nrst = 1'b1;
        cyc();

        // 1: single push then pop; then pop on empty is ignored
        drv(1'b1, 4'h3, 2'b00, 1'b0);
        cyc();
        drv(1'b0, '0, 2'b00, 1'b0);
        chk("t1_valid", 32'(bif.out_valid), 1);
        chk("t1_bid", 32'(bif.out_BID), 3);
        chk("t1_count", 32'(count), 1);
        drv(1'b0, '0, 2'b00, 1'b1);
        cyc();
        chk("t1_pop_count", 32'(count), 0);
        chk("t1_pop_valid", 32'(bif.out_valid), 0);
        cyc();
        chk("t1_empty_pop_count", 32'(count), 0);

        // 2: fill to DEPTH, overflow push ignored, drain in order
        for (int i = 0; i < DEP; i++) begin
            drv(1'b1, IDW'(i), 2'b00, 1'b0);
            cyc();
            chk("t2_fill_count", 32'(count), 32'(i + 1));
            chk("t2_fill_af", 32'(almost_full), (i + 1 >= 4) ? 1 : 0);
        end
        chk("t2_full_in_ready", 32'(bif.in_ready), 0);
        drv(1'b1, 4'h9, 2'b00, 1'b0);
        cyc();
        chk("t2_ovf_count", 32'(count), 6);
        chk("t2_ovf_head", 32'(bif.out_BID), 0);
        drv(1'b0, '0, 2'b00, 1'b1);
        for (int i = 0; i < DEP; i++) begin
            chk("t2_drain_bid", 32'(bif.out_BID), 32'(i));
            cyc();
        end
        chk("t2_drained_count", 32'(count), 0);
        chk("t2_drained_valid", 32'(bif.out_valid), 0);

        // 4: full with simultaneous push/pop -> pop only
        for (int i = 0; i < DEP; i++) begin
            drv(1'b1, IDW'(10 + i), 2'b00, 1'b0);
            cyc();
        end
        chk("t4_full_count", 32'(count), 6);
        drv(1'b1, 4'h1, 2'b00, 1'b1);
        chk("t4_full_in_ready", 32'(bif.in_ready), 0);
        cyc();
        chk("t4_pp_count", 32'(count), 5);
        chk("t4_pp_in_ready", 32'(bif.in_ready), 1);
        chk("t4_pp_head", 32'(bif.out_BID), 32'hB);

        // 3: pop down to count 3 (head D), then stream 20 with push+pop
        drv(1'b0, '0, 2'b00, 1'b1);
        cyc();
        cyc();
        chk("t3_start_count", 32'(count), 3);
        exp_q = '{4'hD, 4'hE, 4'hF};
        for (int k = 0; k < 20; k++) begin
            chk("t3_stream_bid", 32'(bif.out_BID), 32'(exp_q[0]));
            chk("t3_stream_count", 32'(count), 3);
            drv(1'b1, IDW'(k), 2'b00, 1'b1);
            cyc();
            void'(exp_q.pop_front());
            exp_q.push_back(IDW'(k));
        end
        drv(1'b0, '0, 2'b00, 1'b1);
        chk("t3_end_count", 32'(count), 3);
        for (int k = 0; k < 3; k++) begin
            chk("t3_drain_bid", 32'(bif.out_BID), 32'(exp_q[k]));
            cyc();
        end
        chk("t3_drained_count", 32'(count), 0);

        // 5: saturating error counter and err_clr priority
        resp_v = '{2'b10, 2'b11, 2'b00, 2'b10, 2'b11};
        err_v  = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, IDW'(i), resp_v[i], 1'b0);
            cyc();
            chk("t5_err", 32'(err_count), 32'(err_v[i]));
        end
        err_clr = 1'b1;
        drv(1'b1, 4'h5, 2'b10, 1'b0);
        cyc();
        err_clr = 1'b0;
        chk("t5_clr_err", 32'(err_count), 0);
        chk("t5_clr_count", 32'(count), 6);
        chk("t5_head_resp", 32'(bif.out_BRESP), 32'b10);
        drv(1'b0, '0, 2'b00, 1'b1);
        cyc();
        cyc();
        cyc();
        chk("t5_pop3_count", 32'(count), 3);
        drv(1'b1, 4'h9, 2'b11, 1'b0);
        cyc();
        chk("t5_err_one", 32'(err_count), 1);
        chk("t5_count4", 32'(count), 4);

        // 6: flush at count 4 with a push in the same cycle
        flush = 1'b1;
        drv(1'b1, 4'h7, 2'b00, 1'b0);
        chk("t6_flush_in_ready", 32'(bif.in_ready), 1);
        cyc();
        flush = 1'b0;
        chk("t6_flush_count", 32'(count), 0);
        chk("t6_flush_valid", 32'(bif.out_valid), 0);
        chk("t6_flush_err", 32'(err_count), 1);
        drv(1'b1, 4'h5, 2'b00, 1'b0);
        cyc();
        chk("t6_post_bid", 32'(bif.out_BID), 5);
        chk("t6_post_count", 32'(count), 1);
        drv(1'b1, 4'h6, 2'b00, 1'b0);
        cyc();
        chk("t6_post_count2", 32'(count), 2);

        // Asynchronous reset mid-stream
        #2 nrst = 1'b0;
        #1;
        chk("t6_arst_count", 32'(count), 0);
        chk("t6_arst_valid", 32'(bif.out_valid), 0);
        chk("t6_arst_err", 32'(err_count), 0);
        chk("t6_arst_bid", 32'(bif.out_BID), 0);
        drv(1'b0, '0, 2'b00, 1'b0);
        @(negedge clk);
        nrst = 1'b1;
        cyc();
        chk("t6_after_rst_count", 32'(count), 0);
        chk("t6_after_rst_in_ready", 32'(bif.in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/b_resp_fifo.md
Name: b_resp_fifo

Overview:
Single-clock, parametrised AXI write-response (B channel) buffer. It is the next generation of the XBar B-channel FIFO: valid/ready handshakes on both sides, arbitrary (non-power-of-2) depth, first-word-fall-through output, an occupancy count, an almost-full threshold, a synchronous flush, and a saturating error-response counter. It sits between a slave-side B return path and the master-side B mux inside the crossbar, in a single clock domain.

Parameters:
ID_WIDTH, 4, width of BID.
DEPTH, 8, number of entries; any integer >= 2.
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
clk  in  1  clock, all state on the rising edge.
nrst  in  1  asynchronous active-low reset.
flush  in  1  synchronous clear of all entries; the error counter is not cleared.
in_BID  in  ID_WIDTH  write-response ID to enqueue.
in_BRESP  in  2  write response to enqueue.
in_valid  in  1  enqueue request.
in_ready  out  1  space available; equals !full.
out_BID  out  ID_WIDTH  head entry ID; valid only while out_valid=1.
out_BRESP  out  2  head entry response.
out_valid  out  1  FIFO non-empty.
out_ready  in  1  consumer accepts the head.
count  out  $clog2(DEPTH+1)  current occupancy.
almost_full  out  1  count >= AF_THRESH.
err_count  out  ERR_CNT_WIDTH  number of accepted entries with BRESP[1]=1 (SLVERR/DECERR), saturating.
err_clr  in  1  synchronous clear of err_count.

Behaviour:
- Reset (nrst=0, asynchronous): write pointer, read pointer, count and err_count all go to 0. in_ready=1, out_valid=0, almost_full=0. out_BID and out_BRESP are don't-care but must drive 0 after reset.
- Storage: circular buffer of DEPTH entries. Each pointer wraps from DEPTH-1 to 0; there is no power-of-2 assumption. Full and empty are derived from count, not from pointer MSBs.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready depends only on registered state. There is no combinational path from out_ready to in_ready. When the FIFO is full, a push in the same cycle as a pop is refused (in_ready=0).
- FWFT: out_BID and out_BRESP are driven from mem[rd_ptr] combinationally from registered state. A pushed entry appears on the output the cycle after the push (latency 1). There is no bypass when the FIFO is empty.
- count update: next = count + push - pop. Simultaneous push and pop while 0 < count < DEPTH leaves count unchanged; both pointers advance.
- out_valid = (count != 0). in_ready = (count != DEPTH). almost_full is combinational from count.
- Hold rule: while out_valid=1 and out_ready=0, out_BID and out_BRESP stay stable. Pushes must not disturb the head entry.
- flush=1: the next cycle has count=0, rd_ptr=wr_ptr=0 and out_valid=0. Any push or pop in the flush cycle is discarded. in_ready is unaffected by flush in that cycle.
- err_count increments on each push with in_BRESP[1]=1 and saturates at all-ones.
  - err_clr=1 sets err_count to 0 in the next cycle.
  - If err_clr and a counting push occur together, err_clr wins and the result is 0.
  - A flush does not alter err_count.
- Pushing while in_ready=0 or popping while out_valid=0 has no effect: no pointer, count or data change.
- Asserting nrst mid-traffic discards all entries immediately. Outputs reach their reset values combinationally with reset.

Test Plan:
1. Reset, then a single push (ID=4'h3, BRESP=2'b00) -> out_valid=1 in the next cycle, out_BID=3, count=1. Pop -> count=0, out_valid=0.
2. DEPTH=6: push 6 entries with IDs 0..5 -> in_ready=0 and count=6; almost_full=1 from count=4 onward. A 7th push is ignored. Pop all 6 -> IDs come out 0..5 in order.
3. Wrap-around, DEPTH=6: stream 20 entries with in_valid=1 and out_ready=1, starting from count=3 -> count stays 3 throughout, the data sequence is preserved, and the pointers wrap past index 5 correctly.
4. Full and simultaneous push/pop at count=DEPTH -> pop accepted, push refused, count=DEPTH-1. In the next cycle in_ready=1.
5. Error counter, ERR_CNT_WIDTH=2:
   - Push BRESP values 10, 11, 00, 10, 11 -> err_count goes 1, 2, 2, 3, 3 (saturated).
   - err_clr together with a BRESP=10 push -> err_count=0.
6. flush at count=4 with a push in the same cycle -> next cycle count=0, out_valid=0, err_count unchanged. Assert nrst low mid-stream -> count=0 and out_valid=0 immediately, without waiting for a clock edge.
